// File: rtl/ps2_kbd_sender_pkg.sv
// Shared PS/2 sender types: FSM state encoding and frame construction.
// Used by ps2_kbd_sender and its testbench.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      GAP  = 2'd3
   } ps2_state_e;

   localparam int   FRAME_BITS = 11;
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;

   // Frame bit 0 goes on the wire first.
   function automatic logic [FRAME_BITS-1:0] ps2_frame(
      input logic [7:0] b
   );
      return {STOP_BIT, ~^b, b, START_BIT};
   endfunction

endpackage

// File: rtl/ps2_kbd_sender_if.sv
// Byte-push valid/ready handshake into the PS/2 sender buffer.
// The producer uses the master modport, the sender uses the slave modport.
interface ps2_kbd_sender_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/ps2_kbd_sender_tx_fifo.sv
// Synchronous byte FIFO with peek-at-head, registered full flag and count.
// Push is refused whenever full, even when a pop happens in the same cycle.
module ps2_tx_fifo #(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [7:0]    i_wdata,
   input  logic          i_pop,
   output logic [7:0]    o_head,
   output logic          o_empty,
   output logic          o_full,
   output logic [CW-1:0] o_count
);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_full;
   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] w_next_count;

   assign w_push = i_push && !r_full;
   assign w_pop  = i_pop && (r_count != '0);

   always_comb begin
      w_next_count = r_count;
      if (w_push && !w_pop)
         w_next_count = r_count + CW'(1);
      else if (!w_push && w_pop)
         w_next_count = r_count - CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + AW'(1);
         if (w_pop)
            r_rptr <= r_rptr + AW'(1);
         r_count <= w_next_count;
         r_full  <= (w_next_count == CW'(DEPTH));
      end
   end

   // Storage needs no reset; the count gates every read.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= i_wdata;
   end

   assign o_head  = r_mem[r_rptr];
   assign o_empty = (r_count == '0);
   assign o_full  = r_full;
   assign o_count = r_count;

endmodule

// File: rtl/ps2_kbd_sender.sv
// Device-side PS/2 keyboard transmitter: buffered bytes out as 11-bit frames.
// Define PS2_KBD_SENDER_ERRINJ_EN to add err_inject/err_sent parity fault hooks.
module ps2_kbd_sender
   import ps2_pkg::*;
#(
   parameter  int HALF_PERIOD = 2500,
   parameter  int GAP_CYCLES  = 5000,
   parameter  int FIFO_DEPTH  = 4,
   localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic           clk,
   input  logic           clrn,
   ps2_kbd_sender_if.slave tx,
   input  logic           host_inhibit,
`ifdef PS2_KBD_SENDER_ERRINJ_EN
   input  logic           err_inject,
   output logic           err_sent,
`endif
   output logic           ps2_clk,
   output logic           ps2_data,
   output logic           busy,
   output logic [CW-1:0]  fifo_count
);

   localparam int TMAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   ps2_state_e            r_state;
   logic [TW-1:0]         r_cnt;
   logic [3:0]            r_bit_idx;
   logic [FRAME_BITS-1:0] r_frame;
   logic                  r_clk;
   logic                  r_data;

   logic [7:0]            w_head;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_start;
   logic                  w_half_done;
   logic                  w_gap_done;
   logic                  w_last_bit;
   logic                  w_abort;
   logic                  w_flip;
   logic [FRAME_BITS-1:0] w_frame;

   ps2_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (clrn),
      .i_push  (tx.tx_valid),
      .i_wdata (tx.tx_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_count (fifo_count)
   );

   assign tx.tx_ready = !w_full;

   assign w_half_done = (r_cnt == TW'(HALF_PERIOD - 1));
   assign w_gap_done  = (r_cnt == TW'(GAP_CYCLES - 1));
   assign w_last_bit  = (r_bit_idx == 4'd10);
   assign w_abort     = host_inhibit && !w_last_bit;
   assign w_start     = (r_state == IDLE) && !w_empty && !host_inhibit;
   // The head byte leaves the buffer only once its stop bit is complete.
   assign w_pop       = (r_state == LOW) && w_half_done && w_last_bit;

`ifdef PS2_KBD_SENDER_ERRINJ_EN
   logic r_err_frame;
   logic r_err_sent;

   assign w_flip   = err_inject;
   assign err_sent = r_err_sent;

   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         r_err_frame <= 1'b0;
         r_err_sent  <= 1'b0;
      end else begin
         if (w_start)
            r_err_frame <= err_inject;
         if (w_pop && r_err_frame)
            r_err_sent <= 1'b1;
      end
   end
`else
   assign w_flip = 1'b0;
`endif

   assign w_frame = ps2_frame(w_head) ^ {1'b0, w_flip, 9'd0};

   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_frame   <= '1;
         r_clk     <= 1'b1;
         r_data    <= 1'b1;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_clk <= 1'b1;
               if (w_start) begin
                  r_state   <= HIGH;
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_frame   <= w_frame;
                  r_data    <= w_frame[0];
               end else begin
                  r_data <= 1'b1;
               end
            end
            HIGH: begin
               if (w_abort) begin
                  r_state <= GAP;
                  r_cnt   <= '0;
                  r_clk   <= 1'b1;
                  r_data  <= 1'b1;
               end else if (w_half_done) begin
                  r_state <= LOW;
                  r_cnt   <= '0;
                  r_clk   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + TW'(1);
               end
            end
            LOW: begin
               if (w_abort) begin
                  r_state <= GAP;
                  r_cnt   <= '0;
                  r_clk   <= 1'b1;
                  r_data  <= 1'b1;
               end else if (w_half_done) begin
                  r_cnt <= '0;
                  r_clk <= 1'b1;
                  if (w_last_bit) begin
                     r_state <= GAP;
                     r_data  <= 1'b1;
                  end else begin
                     r_state   <= HIGH;
                     r_bit_idx <= r_bit_idx + 4'd1;
                     r_data    <= r_frame[r_bit_idx + 4'd1];
                  end
               end else begin
                  r_cnt <= r_cnt + TW'(1);
               end
            end
            GAP: begin
               r_clk  <= 1'b1;
               r_data <= 1'b1;
               // Inhibit pins the counter so the whole gap restarts on release.
               if (host_inhibit) begin
                  r_cnt <= '0;
               end else if (w_gap_done) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + TW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ps2_clk  = r_clk;
   assign ps2_data = r_data;
   assign busy     = (r_state != IDLE);

endmodule
